bin2bcd_disp: RTL and testbench
===============================

Name: bin2bcd_disp

Overview:
- Sequential binary-to-display converter feeding a bank of DIGITS seven_seg decoders.
- Accepts a W-bit binary value on a start strobe and converts it with iterative shift-add-3 (double-dabble), one bit per clock.
- Applies leading-zero blanking and overflow/sign codes, then presents one 4-bit code plus one enable per digit.
- Codes use the decoder's glyph set: 0-9 digits, 4'hA blank, 4'hB "-", 4'hE "E".

Parameters:
- DIGITS, 4, number of display digits driven.
- W, 14, binary input width. Constraint: 2^W - 1 < 10^(DIGITS+1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset. Synchronous, active-low.
- start  input  1  conversion request, sampled only in IDLE.
- value  input  W  binary value, latched on the accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when digits/dig_en update.
- digits  output  4*DIGITS  per-digit codes; digits[3:0] is the least-significant digit.
- dig_en  output  DIGITS  per-digit enable to the seven_seg en input; bit 0 is the LSD.

Behaviour:
- Reset (rst_n low at a clk edge, in any state including mid-conversion):
  - state=IDLE, busy=0, done=0.
  - every digit = 4'hA, dig_en = 0.
  - internal shift/BCD registers cleared; any in-flight conversion is discarded.
- States: IDLE -> SHIFT -> FORMAT -> IDLE.
- IDLE:
  - On an edge with start=1: latch value into the shift register, clear the (DIGITS+1)-digit BCD accumulator, load bit counter = W, busy<=1, go to SHIFT.
  - start=0: hold.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the counter.
  - After W cycles go to FORMAT.
  - start is ignored; value changes have no effect.
- FORMAT, single cycle:
  - Overflow when the extra top BCD digit is nonzero. Then all digits = 4'hE and dig_en = all ones.
  - Otherwise scan from the MSD down: leading zeros become 4'hA with dig_en=0. The LSD is always shown, so value 0 gives "0".
  - All non-blank digits get dig_en=1.
  - digits/dig_en register on this edge; done<=1, busy<=0, return to IDLE.
- done is high for exactly one cycle. An edge with start=1 in the cycle where done=1 is accepted as a new conversion.
- Latency: start sampled at edge k; busy=1 after edge k; done=1 and new digits visible after edge k+W+1 (W+1 clocks).
- digits/dig_en hold their previous result throughout a conversion and change only on the FORMAT edge.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined:
  - value is two's complement. A negative value is negated on the latch edge and the magnitude is converted.
  - In FORMAT, code 4'hB with dig_en=1 is placed in the first blank position left of the MSD.
  - If the magnitude occupies all DIGITS digits, or the top digit overflows, the result is overflow ("EEEE").
  - Most-negative input (-2^(W-1)) is handled with a W-bit magnitude and no loss.
- Undefined: value is unsigned; no sign logic is compiled.

Test Plan:
- value=0, start pulse -> after 15 clocks: digits=A,A,A,0 (MSD first), dig_en=4'b0001, done single pulse.
- value=1234 -> digits=1,2,3,4, dig_en=4'b1111. value=307 -> A,3,0,7, dig_en=4'b0111. value=9999 -> 9,9,9,9.
- value=10000, and separately value=16383 -> digits=E,E,E,E, dig_en=4'b1111.
- value=42 accepted, then start=1 with value=9 two cycles later -> second start ignored, result 42 (A,A,4,2), busy held 15 cycles.
- value=5678 accepted, rst_n=0 at SHIFT cycle 6 -> digits all A, dig_en=0, busy=0, no done pulse; fresh start then converts normally.
- BIN2BCD_SIGNED_EN:
  - value=14'h3FD6 (-42) -> A,B,4,2, dig_en=4'b0111.
  - -1000 -> E,E,E,E.
  - -8192 -> E,E,E,E.

Source files
------------

// File: rtl/bin2bcd_disp_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_disp_if
//  Description : Handshake/display bundle for bin2bcd_disp.
//                master (requester) drives start/value and observes the
//                busy/done status and per-digit code/enable outputs;
//                slave is the converter side.
//                  start  - conversion request
//                  value  - W-bit binary value
//                  busy   - conversion in progress
//                  done   - one-cycle result-update pulse
//                  digits - 4*DIGITS glyph codes, [3:0] = LSD
//                  dig_en - DIGITS per-digit enables, bit 0 = LSD
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_disp_if #(
    parameter int DIGITS = 4,
    parameter int W      = 14
);
    logic                  start;
    logic [W-1:0]          value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     dig_en;

    modport master (
        output start, value,
        input  busy, done, digits, dig_en
    );

    modport slave (
        input  start, value,
        output busy, done, digits, dig_en
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_disp.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_disp
//  Description : Sequential binary-to-seven-segment-code converter.
//                Double-dabble (shift-add-3) one bit per clock, then a
//                single formatting cycle applies leading-zero blanking,
//                overflow ("EEEE") and, optionally, a minus sign.
//                Glyph codes: 0-9 digits, 4'hA blank, 4'hB '-', 4'hE 'E'.
//  Ports       : clk    - rising-edge clock
//                rst_n  - synchronous active-low reset
//                bus    - bin2bcd_disp_if.slave (start/value in,
//                         busy/done/digits/dig_en out)
//  Options     : BIN2BCD_SIGNED_EN - treat value as two's complement and
//                show a leading '-' for negative inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_disp #(
    parameter int DIGITS = 4,
    parameter int W      = 14
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bin2bcd_disp_if.slave    bus
);

    // One extra BCD digit above the display detects overflow.
    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2
    } state_t;

    state_t                 state_q;
    logic [W-1:0]           bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [4*DIGITS-1:0]    digits_q;
    logic [DIGITS-1:0]      dig_en_q;
`ifdef BIN2BCD_SIGNED_EN
    logic                   neg_q;
`endif

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_d;
    logic [4*DIGITS-1:0]    digits_d;
    logic [DIGITS-1:0]      dig_en_d;
    logic                   ovf;
    logic                   seen;
    int                     msd_idx;

    // Add-3 correction on every nibble, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i <= DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[W-1]};
    end

    // Formatting of the finished BCD accumulator.
    always_comb begin
        digits_d = '0;
        dig_en_d = '0;
        seen     = 1'b0;
        msd_idx  = 0;
        ovf      = (bcd_q[BCD_W-1 -: 4] != 4'd0);

        // Scan from the MSD: blank until the first nonzero digit; the LSD
        // is always shown so that zero reads "0".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (seen || (bcd_q[4*i +: 4] != 4'd0) || (i == 0)) begin
                if (!seen) begin
                    msd_idx = i;
                end
                seen        = 1'b1;
                digits_d[4*i +: 4] = bcd_q[4*i +: 4];
                dig_en_d[i] = 1'b1;
            end else begin
                digits_d[4*i +: 4] = 4'hA;
            end
        end

`ifdef BIN2BCD_SIGNED_EN
        // The sign needs a free digit left of the MSD.
        if (neg_q) begin
            if (msd_idx == DIGITS - 1) begin
                ovf = 1'b1;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (i == msd_idx + 1) begin
                        digits_d[4*i +: 4] = 4'hB;
                        dig_en_d[i]        = 1'b1;
                    end
                end
            end
        end
`endif

        if (ovf) begin
            for (int i = 0; i < DIGITS; i++) begin
                digits_d[4*i +: 4] = 4'hE;
            end
            dig_en_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dig_en_q <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                digits_q[4*i +: 4] <= 4'hA;
            end
`ifdef BIN2BCD_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
`ifdef BIN2BCD_SIGNED_EN
                        // Negation of -2^(W-1) wraps to 2^(W-1), which is
                        // still exact when read as an unsigned magnitude.
                        neg_q <= bus.value[W-1];
                        bin_q <= bus.value[W-1] ? (~bus.value + 1'b1) : bus.value;
`else
                        bin_q <= bus.value;
`endif
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(W);
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= {bin_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_FORMAT;
                    end
                end
                S_FORMAT: begin
                    digits_q <= digits_d;
                    dig_en_q <= dig_en_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.digits = digits_q;
    assign bus.dig_en = dig_en_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_disp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_disp
//  Description : Directed self-checking bench for bin2bcd_disp
//                (DIGITS=4, W=14). Expected codes are hand-derived.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_disp;

    localparam int DIGITS = 4;
    localparam int W      = 14;
    localparam int LAT    = W + 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bin2bcd_disp_if #(.DIGITS(DIGITS), .W(W)) bus ();

    bin2bcd_disp #(.DIGITS(DIGITS), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.digits !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL reset_digits: got %h expected aaaa", bus.digits);
        end
        n_checks++;
        if (bus.dig_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_dig_en: got %b expected 0000", bus.dig_en);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full conversion: checks latency, busy during conversion, result,
    // and that done is a single-cycle pulse.
    task automatic run_conv(input logic [W-1:0] v, input logic [15:0] exp_d,
                            input logic [3:0] exp_en, input string name);
        int edges;
        logic busy_ok;
        bus.start = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.start = 1'b0;
        edges   = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && edges < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges - 1 != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, edges - 1, LAT);
            return;
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s_busy: got busy low during conversion expected high", name);
        end
        n_checks++;
        if (bus.digits !== exp_d || bus.dig_en !== exp_en) begin
            n_fail++;
            $display("FAIL %s_result: got %h/%b expected %h/%b", name,
                     bus.digits, bus.dig_en, exp_d, exp_en);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: got done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_values();
        run_conv(14'd0,    16'hAAA0, 4'b0001, "zero");
        run_conv(14'd1234, 16'h1234, 4'b1111, "v1234");
        run_conv(14'd307,  16'hA307, 4'b0111, "v307");
        run_conv(14'd42,   16'hAA42, 4'b0011, "v42");
    endtask

`ifndef BIN2BCD_SIGNED_EN
    task automatic test_overflow();
        run_conv(14'd9999,  16'h9999, 4'b1111, "v9999");
        run_conv(14'd10000, 16'hEEEE, 4'b1111, "v10000");
        run_conv(14'd16383, 16'hEEEE, 4'b1111, "v16383");
    endtask
`else
    task automatic test_signed();
        run_conv(14'h3FD6, 16'hAB42, 4'b0111, "neg42");
        run_conv(14'h3C18, 16'hEEEE, 4'b1111, "neg1000");
        run_conv(14'h2000, 16'hEEEE, 4'b1111, "neg8192");
    endtask
`endif

    task automatic test_start_ignored();
        int guard;
        int busy_cnt;
        bus.start = 1'b1;
        bus.value = 14'd42;
        @(negedge clk);
        bus.start = 1'b0;
        guard    = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && guard < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (guard == 2) begin
                bus.start = 1'b1;
                bus.value = 14'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (busy_cnt != LAT) begin
            n_fail++;
            $display("FAIL ignore_busy_cycles: got %0d expected %0d", busy_cnt, LAT);
        end
        n_checks++;
        if (bus.digits !== 16'hAA42 || bus.dig_en !== 4'b0011) begin
            n_fail++;
            $display("FAIL ignore_result: got %h/%b expected aa42/0011", bus.digits, bus.dig_en);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        bus.start = 1'b1;
        bus.value = 14'd1234;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        // New request presented in the done cycle.
        bus.start = 1'b1;
        bus.value = 14'd307;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy);
        end
        n_checks++;
        if (bus.digits !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h expected 1234", bus.digits);
        end
        guard = 1;
        while (bus.done !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard - 1 != LAT) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d expected %0d", guard - 1, LAT);
        end
        n_checks++;
        if (bus.digits !== 16'hA307 || bus.dig_en !== 4'b0111) begin
            n_fail++;
            $display("FAIL b2b_result: got %h/%b expected a307/0111", bus.digits, bus.dig_en);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midconv();
        logic saw_done;
        bus.start = 1'b1;
        bus.value = 14'd5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.digits !== 16'hAAAA || bus.dig_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h/%b expected aaaa/0000", bus.digits, bus.dig_en);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_busy: got %b expected 0", bus.busy);
        end
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL midrst_no_done: got activity after reset expected none");
        end
        run_conv(14'd1234, 16'h1234, 4'b1111, "after_rst");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_values();
`ifndef BIN2BCD_SIGNED_EN
        test_overflow();
`else
        test_signed();
`endif
        test_start_ignored();
        test_back_to_back();
        test_reset_midconv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
